// File: rtl/fpu_op_arbiter.sv
// rtl/fpu_op_arbiter.sv - two-requester round-robin front end for a shared FP datapath
//
// Purpose:
//   Accepts single-precision operations from two requesters, grants one at a
//   time in round-robin order, launches the shared FP datapath, waits for its
//   result and returns it to the granted requester.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/req_ready [1:0]  per-requester handshake (ready is the grant)
//   req_a/req_b [63:0]         operands, requester i in bits [32i+31:32i]
//   req_op [3:0]               opcode, requester i in bits [2i+1:2i]
//   rsp_valid [1:0]            one-cycle response pulse for requester i
//   rsp_result [31:0], rsp_err shared response payload, held between responses
//   alu_start, alu_a/b, alu_op launch pulse and registered operands for datapath
//   alu_done, alu_result       datapath completion pulse and result
//
// Configuration:
//   FPU_ARB_TIMEOUT_EN  when defined, a watchdog of TIMEOUT_CYCLES WAIT cycles
//                       ends a stalled operation with a quiet NaN and rsp_err=1.

module fpu_op_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [3:0]  req_op,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic        alu_done,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        alu_start_q, alu_start_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        win;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Requester picked this cycle: a lone requester always wins; under
  // contention the one that was not served last wins.
  assign win = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];

  // The grant must be visible in the cycle the operands are sampled, so
  // req_ready is the one combinational output. Reset masks it so nothing is
  // accepted while the FSM is being cleared.
  assign req_ready = (!reset && state_q == S_IDLE && |req_valid)
                     ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign alu_start  = alu_start_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_start_d  = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = 2'b00;
    rsp_result_d = rsp_result_q;
`ifdef FPU_ARB_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    rsp_err_d    = rsp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_d     = win;
          alu_a_d     = win ? req_a[63:32] : req_a[31:0];
          alu_b_d     = win ? req_b[63:32] : req_b[31:0];
          alu_op_d    = win ? req_op[3:2]  : req_op[1:0];
          // alu_start is registered, so it is high for the whole ISSUE cycle.
          alu_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end

      S_WAIT: begin
        // A completion in the expiry cycle takes precedence over the watchdog.
        if (alu_done) begin
          rsp_result_d = alu_result;
`ifdef FPU_ARB_TIMEOUT_EN
          rsp_err_d    = 1'b0;
`endif
          state_d      = S_RESP;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (wd_cnt_q == CNT_LAST) begin
          rsp_result_d = QNAN;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        // The response pulse is registered, so it lands in the first cycle
        // back in IDLE; a new grant may overlap it.
        rsp_valid_d  = grant_q ? 2'b10 : 2'b01;
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      wd_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_start_q  <= alu_start_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
`ifdef FPU_ARB_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// tb/tb_fpu_op_arbiter.sv - self-checking bench for fpu_op_arbiter

module tb_fpu_op_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b11;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_op = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        alu_start;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = '0;

  fpu_op_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_last = 1;

  // Event logs captured at the falling edge.
  typedef struct { int cyc; int idx; logic [63:0] a; logic [63:0] b; logic [3:0] op; } gr_t;
  typedef struct { int cyc; logic [31:0] a; logic [31:0] b; logic [1:0] op; } st_t;
  typedef struct { int cyc; logic [1:0] v; logic [31:0] res; logic err; } rs_t;
  gr_t gr_q[$];
  st_t st_q[$];
  rs_t rsp_q[$];

  always @(negedge clk) begin
    if (req_ready != 2'b00)
      gr_q.push_back('{cyc, (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 2,
                       req_a, req_b, req_op});
    if (alu_start === 1'b1) st_q.push_back('{cyc, alu_a, alu_b, alu_op});
    if (rsp_valid != 2'b00) rsp_q.push_back('{cyc, rsp_valid, rsp_result, rsp_err});
  end

  // Datapath model: done arrives L cycles after the alu_start cycle.
  int          alu_lat = 0;       // 0 selects a random latency 2..6
  bit          alu_never = 1'b0;
  bit          alu_fixed_en = 1'b0;
  logic [31:0] alu_fixed = '0;
  bit          spur = 1'b0;
  int          cd = 0;
  int          lm;
  logic        st_m;
  logic [31:0] ret_pend = '0;
  int          lat_log[$];
  logic [31:0] ret_log[$];

  always @(posedge clk) begin
    st_m = alu_start;
    #1;
    alu_done   = 1'b0;
    alu_result = $urandom;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        alu_done   = 1'b1;
        alu_result = ret_pend;
      end
    end
    if (spur) begin
      alu_done = 1'b1;
      spur     = 1'b0;
    end
    if (st_m === 1'b1) begin
      lm       = alu_never ? 1000 : ((alu_lat != 0) ? alu_lat : int'($urandom_range(2, 6)));
      ret_pend = alu_fixed_en ? alu_fixed : $urandom;
      lat_log.push_back(lm);
      ret_log.push_back(ret_pend);
      if (!alu_never) cd = lm - 1;
    end
  end

  // Reference rules.
  function automatic int exp_winner(logic [1:0] vld, int last);
    if (vld == 2'b01) return 0;
    if (vld == 2'b10) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  function automatic int exp_lat(int l);
`ifdef FPU_ARB_TIMEOUT_EN
    if (l > TO) return TO + 3;
`endif
    return l + 3;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gr_q.delete(); st_q.delete(); rsp_q.delete();
    lat_log.delete(); ret_log.delete();
    exp_last = 1;
  endtask

  // Holds vld (with operands re-randomised every cycle) until ngr grants are
  // seen, then waits for nrsp responses.
  task automatic drive_ops(input logic [1:0] vld, input int ngr, input int nrsp);
    int budget = 0;
    while ((gr_q.size() < ngr || rsp_q.size() < nrsp) && budget < 400) begin
      @(posedge clk); #1;
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      req_op    = 4'($urandom);
      req_valid = (gr_q.size() < ngr) ? vld : 2'b00;
      budget++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", req_ready); end
    checks++; if ({rsp_valid, rsp_result, rsp_err} !== 35'd0) begin errors++; $display("FAIL reset_rsp: got v=%b r=%h e=%b exp 0", rsp_valid, rsp_result, rsp_err); end
    checks++; if ({alu_start, alu_a, alu_b, alu_op} !== 67'd0) begin errors++; $display("FAIL reset_alu: got s=%b a=%h b=%h op=%b exp 0", alu_start, alu_a, alu_b, alu_op); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b exp 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL reset_issue_start: got %b exp 1", alu_start); end
  endtask

  task automatic test_single();
    do_reset();
    alu_lat = 4; alu_fixed_en = 1'b1; alu_fixed = 32'h4040_0000;
    @(posedge clk); #1;
    req_a = {$urandom, 32'h3F80_0000};
    req_b = {$urandom, 32'h4000_0000};
    req_op = {2'($urandom), 2'b00};
    req_valid = 2'b01;
    for (int i = 0; i < 20 && gr_q.size() == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    for (int i = 0; i < 40 && rsp_q.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (gr_q.size() != 1 || st_q.size() != 1 || rsp_q.size() != 1) begin errors++; $display("FAIL single_counts: got gr=%0d st=%0d rsp=%0d exp 1 1 1", gr_q.size(), st_q.size(), rsp_q.size()); end
    if (gr_q.size() >= 1 && st_q.size() >= 1 && rsp_q.size() >= 1) begin
      checks++; if (gr_q[0].idx != 0) begin errors++; $display("FAIL single_grant: got %0d exp 0", gr_q[0].idx); end
      checks++; if (st_q[0].cyc - gr_q[0].cyc != 1) begin errors++; $display("FAIL single_start_delay: got %0d exp 1", st_q[0].cyc - gr_q[0].cyc); end
      checks++; if ({st_q[0].a, st_q[0].b, st_q[0].op} !== {32'h3F80_0000, 32'h4000_0000, 2'b00}) begin errors++; $display("FAIL single_operands: got a=%h b=%h op=%b exp 3f800000 40000000 00", st_q[0].a, st_q[0].b, st_q[0].op); end
      checks++; if (rsp_q[0].v !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b exp 01", rsp_q[0].v); end
      checks++; if (rsp_q[0].cyc - gr_q[0].cyc != 7) begin errors++; $display("FAIL single_latency: got %0d exp 7", rsp_q[0].cyc - gr_q[0].cyc); end
      checks++; if (rsp_q[0].res !== 32'h4040_0000 || rsp_q[0].err !== 1'b0) begin errors++; $display("FAIL single_result: got %h err %b exp 40400000 err 0", rsp_q[0].res, rsp_q[0].err); end
    end
    alu_fixed_en = 1'b0; alu_lat = 0;
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    drive_ops(2'b11, 4, 4);
    checks++; if (gr_q.size() != 4 || rsp_q.size() != 4) begin errors++; $display("FAIL rr_counts: got gr=%0d rsp=%0d exp 4 4", gr_q.size(), rsp_q.size()); end
    for (int k = 0; k < 4 && k < gr_q.size() && k < rsp_q.size() && k < st_q.size(); k++) begin
      e = exp_winner(2'b11, exp_last);
      checks++; if (gr_q[k].idx != e) begin errors++; $display("FAIL rr_grant[%0d]: got %0d exp %0d", k, gr_q[k].idx, e); end
      checks++; if ({st_q[k].a, st_q[k].b, st_q[k].op} !== {gr_q[k].a[32*e +: 32], gr_q[k].b[32*e +: 32], gr_q[k].op[2*e +: 2]}) begin errors++; $display("FAIL rr_operands[%0d]: got a=%h b=%h op=%b", k, st_q[k].a, st_q[k].b, st_q[k].op); end
      checks++; if (rsp_q[k].v !== (2'b01 << e) || rsp_q[k].res !== ret_log[k] || rsp_q[k].err !== 1'b0) begin errors++; $display("FAIL rr_rsp[%0d]: got v=%b r=%h e=%b exp v=%b r=%h e=0", k, rsp_q[k].v, rsp_q[k].res, rsp_q[k].err, 2'b01 << e, ret_log[k]); end
      checks++; if (rsp_q[k].cyc - gr_q[k].cyc != exp_lat(lat_log[k])) begin errors++; $display("FAIL rr_latency[%0d]: got %0d exp %0d", k, rsp_q[k].cyc - gr_q[k].cyc, exp_lat(lat_log[k])); end
      exp_last = e;
    end
  endtask

  task automatic test_lone_requester();
    int e;
    do_reset();
    drive_ops(2'b10, 3, 3);
    checks++; if (gr_q.size() != 3 || rsp_q.size() != 3) begin errors++; $display("FAIL lone_counts: got gr=%0d rsp=%0d exp 3 3", gr_q.size(), rsp_q.size()); end
    for (int k = 0; k < 3 && k < gr_q.size() && k < rsp_q.size(); k++) begin
      e = exp_winner(2'b10, exp_last);
      checks++; if (gr_q[k].idx != e) begin errors++; $display("FAIL lone_grant[%0d]: got %0d exp %0d", k, gr_q[k].idx, e); end
      checks++; if (rsp_q[k].v !== (2'b01 << e) || rsp_q[k].res !== ret_log[k]) begin errors++; $display("FAIL lone_rsp[%0d]: got v=%b r=%h exp v=%b r=%h", k, rsp_q[k].v, rsp_q[k].res, 2'b01 << e, ret_log[k]); end
      exp_last = e;
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    alu_lat = 10;
    @(posedge clk); #1;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_op = 4'($urandom);
    req_valid = 2'b10;
    for (int i = 0; i < 20 && gr_q.size() == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 20 && st_q.size() == 0; i++) @(negedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_op} !== 104'd0) begin errors++; $display("FAIL midreset_outputs: got rr=%b v=%b r=%h e=%b s=%b a=%h b=%h op=%b exp 0", req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, alu_b, alu_op); end
    repeat (15) @(negedge clk);
    checks++; if (rsp_q.size() != 0 || gr_q.size() != 1) begin errors++; $display("FAIL midreset_no_rsp: got rsp=%0d gr=%0d exp 0 1", rsp_q.size(), gr_q.size()); end
    alu_lat = 0;
    exp_last = 1;
    drive_ops(2'b11, 2, 1);
    checks++; if (gr_q.size() != 2 || rsp_q.size() != 1) begin errors++; $display("FAIL midreset_next_counts: got gr=%0d rsp=%0d exp 2 1", gr_q.size(), rsp_q.size()); end
    if (gr_q.size() == 2 && rsp_q.size() == 1 && lat_log.size() == 2) begin
      checks++; if (gr_q[1].idx != exp_winner(2'b11, exp_last)) begin errors++; $display("FAIL midreset_next_grant: got %0d exp %0d", gr_q[1].idx, exp_winner(2'b11, exp_last)); end
      checks++; if (rsp_q[0].v !== 2'b01 || rsp_q[0].res !== ret_log[1] || rsp_q[0].cyc - gr_q[1].cyc != exp_lat(lat_log[1])) begin errors++; $display("FAIL midreset_next_rsp: got v=%b r=%h lat=%0d exp v=01 r=%h lat=%0d", rsp_q[0].v, rsp_q[0].res, rsp_q[0].cyc - gr_q[1].cyc, ret_log[1], exp_lat(lat_log[1])); end
    end
  endtask

  task automatic test_spurious_done();
    logic [31:0] hold_res;
    logic [31:0] hold_a;
    do_reset();
    alu_lat = 3;
    drive_ops(2'b10, 1, 1);
    checks++; if (rsp_q.size() != 1 || gr_q.size() != 1) begin errors++; $display("FAIL spur_setup: got rsp=%0d gr=%0d exp 1 1", rsp_q.size(), gr_q.size()); end
    if (rsp_q.size() == 1 && gr_q.size() == 1) begin
      hold_res = ret_log[0];
      hold_a   = gr_q[0].a[63:32];
      repeat (2) @(posedge clk);
      #1 spur = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++; if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a} !== {2'b00, 2'b00, hold_res, 1'b0, 1'b0, hold_a}) begin errors++; $display("FAIL spur_hold[%0d]: got rr=%b v=%b r=%h e=%b s=%b a=%h exp r=%h a=%h", i, req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_a, hold_res, hold_a); end
      end
      @(posedge clk); #1;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL spur_still_idle: got %b exp 01", req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      for (int i = 0; i < 40 && rsp_q.size() < 2; i++) @(negedge clk);
      checks++; if (rsp_q.size() != 2 || lat_log.size() != 2 || gr_q.size() != 2) begin errors++; $display("FAIL spur_next_counts: got rsp=%0d exp 2", rsp_q.size()); end
      else begin
        checks++; if (rsp_q[1].cyc - gr_q[1].cyc != exp_lat(lat_log[1]) || rsp_q[1].res !== ret_log[1]) begin errors++; $display("FAIL spur_next_rsp: got lat=%0d r=%h exp lat=%0d r=%h", rsp_q[1].cyc - gr_q[1].cyc, rsp_q[1].res, exp_lat(lat_log[1]), ret_log[1]); end
      end
    end
    alu_lat = 0;
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int tl[4] = '{0, 8, 9, 3};
    int el;
    logic [31:0] er;
    logic ee;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      alu_never = (tl[k] == 0);
      alu_lat   = tl[k];
      drive_ops(2'b01, k + 1, k + 1);
    end
    alu_never = 1'b0; alu_lat = 0;
    checks++; if (rsp_q.size() != 4 || gr_q.size() != 4 || lat_log.size() != 4) begin errors++; $display("FAIL timeout_counts: got rsp=%0d gr=%0d exp 4 4", rsp_q.size(), gr_q.size()); end
    for (int k = 0; k < 4 && k < rsp_q.size() && k < gr_q.size() && k < lat_log.size(); k++) begin
      el = exp_lat(lat_log[k]);
      ee = (lat_log[k] > TO);
      er = ee ? 32'h7FC0_0000 : ret_log[k];
      checks++; if (rsp_q[k].cyc - gr_q[k].cyc != el) begin errors++; $display("FAIL timeout_latency[%0d]: got %0d exp %0d", k, rsp_q[k].cyc - gr_q[k].cyc, el); end
      checks++; if (rsp_q[k].v !== 2'b01 || rsp_q[k].res !== er || rsp_q[k].err !== ee) begin errors++; $display("FAIL timeout_rsp[%0d]: got v=%b r=%h e=%b exp v=01 r=%h e=%b", k, rsp_q[k].v, rsp_q[k].res, rsp_q[k].err, er, ee); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lone_requester();
    test_reset_mid_op();
    test_spurious_done();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "time limit");
  end

endmodule
